// File: rtl/apb_multi_slave_bridge_if.sv
// APB bus bundle for the multi-slave bridge.
// The "slave" modport is the bridge's face towards the system APB master;
// the "master" modport is its face towards the shared peripheral bus.
interface apb_multi_slave_bridge_if #(
    parameter int NUM_SLAVES = 4
);
    // Master-side APB3 signals
    logic [31:0]             PADDR;
    logic                    PWRITE;
    logic                    PSEL;
    logic                    PENABLE;
    logic [31:0]             PWDATA;
    logic [31:0]             PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    // Shared peripheral bus with per-slave select and response lanes
    logic [31:0]             S_PADDR;
    logic                    S_PWRITE;
    logic [31:0]             S_PWDATA;
    logic                    S_PENABLE;
    logic [NUM_SLAVES-1:0]   S_PSEL;
    logic [32*NUM_SLAVES-1:0] S_PRDATA;
    logic [NUM_SLAVES-1:0]   S_PREADY;
    logic [NUM_SLAVES-1:0]   S_PSLVERR;

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

    modport master (
        output S_PADDR, S_PWRITE, S_PWDATA, S_PENABLE, S_PSEL,
        input  S_PRDATA, S_PREADY, S_PSLVERR
    );
endinterface

// File: rtl/apb_multi_slave_bridge.sv
// APB3 bridge: one master to NUM_SLAVES peripherals through a field decoder,
// with a default error slave, a per-transfer wait-state watchdog and a
// saturating error counter. Zero added latency: the setup phase is
// recognised in the cycle the master presents it.
module apb_multi_slave_bridge #(
    parameter int          NUM_SLAVES    = 4,
    parameter int          DEC_LSB       = 12,
    parameter int          DEC_BITS      = 3,
    parameter int          TIMEOUT       = 16,
    parameter logic [31:0] DEFAULT_RDATA = 32'h0000_00AF
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    apb_multi_slave_bridge_if.slave          up_bus,
    apb_multi_slave_bridge_if.master         dn_bus,
    output logic [15:0]                      ERR_CNT,
    output logic                             TIMEOUT_PULSE
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    localparam logic        TMO_EN  = (TIMEOUT != 0);
    localparam logic [15:0] TMO_VAL = 16'(TIMEOUT);

    // state_q only ever holds IDLE or ACCESS; SETUP is the phase seen when a
    // fresh request appears while idle, so no cycle is lost to registering it.
    state_t                state_q, state_d, phase;
    logic [DEC_BITS-1:0]   idx_live, idx_q;
    logic                  hit_live, dflt_q;
    logic [15:0]           wait_cnt, err_cnt_q;
    logic                  pulse_q;
    logic                  lane_ready, lane_err;
    logic [31:0]           lane_rdata;
    logic                  in_access, timeout_hit;
    logic                  rdy, err;
    logic [31:0]           rdata;
    logic [NUM_SLAVES-1:0] sel;
    logic                  penable;

    assign idx_live = up_bus.PADDR[DEC_LSB +: DEC_BITS];
    assign hit_live = (32'(idx_live) < NUM_SLAVES);

    // Phase decode, slave lane mux, watchdog, response and next-state logic
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        phase      = state_q;
        state_d    = state_q;
        lane_ready = 1'b0;
        lane_err   = 1'b0;
        lane_rdata = '0;
        rdy        = 1'b0;
        err        = 1'b0;
        rdata      = '0;
        sel        = '0;
        penable    = 1'b0;

        if (state_q == ST_IDLE && up_bus.PSEL && !up_bus.PENABLE)
            phase = ST_SETUP;

        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == DEC_BITS'(i)) begin
                lane_ready = dn_bus.S_PREADY[i];
                lane_err   = dn_bus.S_PSLVERR[i];
                lane_rdata = dn_bus.S_PRDATA[32*i +: 32];
            end
        end

        in_access   = (phase == ST_ACCESS) && up_bus.PSEL;
        timeout_hit = in_access && !dflt_q && !lane_ready && TMO_EN &&
                      (wait_cnt == TMO_VAL);

        if (in_access) begin
            if (dflt_q) begin
                rdy   = 1'b1;
                err   = 1'b1;
                rdata = DEFAULT_RDATA;
            end else if (timeout_hit) begin
                rdy   = 1'b1;
                err   = 1'b1;
            end else begin
                rdy   = lane_ready;
                err   = lane_ready && lane_err;
                rdata = lane_rdata;
                penable = up_bus.PENABLE;
                for (int i = 0; i < NUM_SLAVES; i++)
                    sel[i] = (idx_q == DEC_BITS'(i));
            end
        end else if (phase != ST_ACCESS && up_bus.PSEL && hit_live) begin
            for (int i = 0; i < NUM_SLAVES; i++)
                sel[i] = (idx_live == DEC_BITS'(i));
        end

        case (phase)
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (!up_bus.PSEL || rdy) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Everything the bridge drives is held at zero while reset is asserted
    assign up_bus.PREADY    = !PRESET && rdy;
    assign up_bus.PSLVERR   = !PRESET && err;
    assign up_bus.PRDATA    = PRESET ? '0 : rdata;
    assign dn_bus.S_PSEL    = PRESET ? '0 : sel;
    assign dn_bus.S_PENABLE = !PRESET && penable;
    assign dn_bus.S_PADDR   = PRESET ? '0 : up_bus.PADDR;
    assign dn_bus.S_PWRITE  = !PRESET && up_bus.PWRITE;
    assign dn_bus.S_PWDATA  = PRESET ? '0 : up_bus.PWDATA;
    assign ERR_CNT          = PRESET ? '0 : err_cnt_q;
    assign TIMEOUT_PULSE    = !PRESET && pulse_q;

    // State register, latched target slave and wait-state counter
    always_ff @(posedge PCLK) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the values from before this edge, independent of statement order.
        if (PRESET) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            dflt_q   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (phase == ST_SETUP) begin
                idx_q    <= idx_live;
                dflt_q   <= !hit_live;
                wait_cnt <= '0;
            end else if (in_access && !dflt_q && !lane_ready) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    // Saturating error counter and one-cycle watchdog pulse
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            err_cnt_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            pulse_q <= timeout_hit;
            if (rdy && err && err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end
endmodule
